// File: rtl/sequential_divider_if.sv
// Interface for sequential_divider: the control inputs, the operands and the
// result/status outputs. The requester uses the master modport and the divider
// uses the slave modport.
interface sequential_divider_if #(
    parameter int N = 32
);
    logic             en;
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic [N-1:0]     quotient;
    logic [N-1:0]     remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output en, start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  en, start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero, overflow
    );
endinterface

// File: rtl/sequential_divider.sv
// Signed iterative restoring divider: a 2N-bit dividend divided by an N-bit
// divisor, one quotient bit per enabled clock, quotient truncated toward zero
// and remainder carrying the sign of the dividend. Division by zero and
// quotient overflow end early (or at the sign stage) with sticky flags.
module sequential_divider #(
    parameter int N = 32
) (
    input  logic                clk,
    input  logic                reset,
    sequential_divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, SIGN, ERR} state_t;

    localparam int            CW        = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
    // Largest magnitude a negative N-bit quotient may have: 2^(N-1).
    localparam logic [N-1:0]  NEG_LIMIT = {1'b1, {(N-1){1'b0}}};

    state_t         state_reg;
    state_t         state_next;
    logic [CW-1:0]  count_reg;
    logic [N-1:0]   rem_reg;        // partial remainder magnitude
    logic [N-1:0]   lo_reg;         // dividend bits shift out the top, quotient bits shift in the bottom
    logic [N-1:0]   dvs_reg;        // divisor magnitude
    logic           sign_q_reg;
    logic           sign_r_reg;
    logic           err_dz_reg;     // error path cause: 1 = divide by zero, 0 = overflow
    logic [N-1:0]   quotient_reg;
    logic [N-1:0]   remainder_reg;
    logic           busy_reg;
    logic           done_reg;
    logic           dz_flag_reg;
    logic           ovf_flag_reg;

    logic [2*N-1:0] dvd_mag;
    logic [N-1:0]   dvs_mag;
    logic           divisor_zero;
    logic           pre_ovf;
    logic [N:0]     trial;
    logic           step_ge;
    logic [N-1:0]   step_rem;
    logic           q_ovf;
    logic [N-1:0]   q_signed;
    logic [N-1:0]   r_signed;

    // Operand magnitudes and the up-front overflow test, evaluated at the start edge.
    // The most negative dividend maps to 2^(2N-1), which is representable unsigned.
    assign dvd_mag      = bus.dividend[2*N-1] ? -bus.dividend : bus.dividend;
    assign dvs_mag      = bus.divisor[N-1] ? -bus.divisor : bus.divisor;
    assign divisor_zero = (bus.divisor == '0);
    assign pre_ovf      = (dvd_mag[2*N-1:N] >= dvs_mag);

    // One restoring step: shift in the next dividend bit and try subtracting the divisor.
    // When the trial succeeds the difference is below the divisor, so N-bit wrap-around
    // subtraction gives the exact result.
    assign trial    = {rem_reg, lo_reg[N-1]};
    assign step_ge  = (trial >= {1'b0, dvs_reg});
    assign step_rem = step_ge ? (trial[N-1:0] - dvs_reg) : trial[N-1:0];

    // Sign restoration and the final range check on the magnitude quotient.
    assign q_ovf    = sign_q_reg ? (lo_reg > NEG_LIMIT) : lo_reg[N-1];
    assign q_signed = sign_q_reg ? -lo_reg : lo_reg;
    assign r_signed = sign_r_reg ? -rem_reg : rem_reg;

    // State register; en=0 freezes the FSM, reset wins over en.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else if (bus.en) begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (divisor_zero || pre_ovf) begin
                        state_next = ERR;
                    end else begin
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (count_reg == LAST_STEP) begin
                    state_next = SIGN;
                end
            end
            SIGN:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath, result registers and status flags, all advancing only on enabled edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg     <= '0;
            rem_reg       <= '0;
            lo_reg        <= '0;
            dvs_reg       <= '0;
            sign_q_reg    <= 1'b0;
            sign_r_reg    <= 1'b0;
            err_dz_reg    <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            dz_flag_reg   <= 1'b0;
            ovf_flag_reg  <= 1'b0;
        end else if (bus.en) begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        sign_q_reg   <= bus.dividend[2*N-1] ^ bus.divisor[N-1];
                        sign_r_reg   <= bus.dividend[2*N-1];
                        dvs_reg      <= dvs_mag;
                        rem_reg      <= dvd_mag[2*N-1:N];
                        // A zero divisor never runs CALC, so lo_reg keeps the raw low
                        // dividend bits that the error result reports as remainder.
                        lo_reg       <= divisor_zero ? bus.dividend[N-1:0] : dvd_mag[N-1:0];
                        err_dz_reg   <= divisor_zero;
                        dz_flag_reg  <= 1'b0;
                        ovf_flag_reg <= 1'b0;
                        count_reg    <= '0;
                        busy_reg     <= 1'b1;
                    end
                end
                CALC: begin
                    rem_reg   <= step_rem;
                    lo_reg    <= {lo_reg[N-2:0], step_ge};
                    count_reg <= count_reg + CW'(1);
                end
                SIGN: begin
                    if (q_ovf) begin
                        ovf_flag_reg  <= 1'b1;
                        quotient_reg  <= '0;
                        remainder_reg <= '0;
                    end else begin
                        quotient_reg  <= q_signed;
                        remainder_reg <= r_signed;
                    end
                    done_reg <= 1'b1;
                    busy_reg <= 1'b0;
                end
                ERR: begin
                    quotient_reg  <= err_dz_reg ? '1 : '0;
                    remainder_reg <= err_dz_reg ? lo_reg : '0;
                    dz_flag_reg   <= err_dz_reg;
                    ovf_flag_reg  <= ~err_dz_reg;
                    done_reg      <= 1'b1;
                    busy_reg      <= 1'b0;
                end
                default: begin
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.div_by_zero = dz_flag_reg;
    assign bus.overflow    = ovf_flag_reg;
endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider (N=32): a table of directed
// vectors, hand-written control sequences (enable stall, ignored start,
// frozen done, reset mid-operation) and randomized operands checked against
// an arithmetic reference model.
module tb_sequential_divider;
    localparam int N = 32;

    typedef struct {
        logic signed [63:0] a;
        logic signed [31:0] b;
        logic signed [31:0] q;
        logic signed [31:0] r;
        logic               dz;
        logic               ovf;
        int                 lat;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    vec_t vecs[13];

    sequential_divider_if #(.N(N)) bus();

    sequential_divider #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact signed arithmetic on wide integers, following the
    // divide-by-zero, |quotient| >= 2^N and signed-range rules.
    function automatic void ref_div(input logic signed [63:0] a, input logic signed [31:0] b,
                                    output logic signed [31:0] q, output logic signed [31:0] r,
                                    output logic dz, output logic ovf, output int lat);
        logic signed [65:0] aw, bw, ma, mb, qq, rr;
        aw = a;
        bw = b;
        dz = 1'b0; ovf = 1'b0; q = '0; r = '0; lat = 33;
        if (b == 0) begin
            dz  = 1'b1;
            q   = -32'sd1;
            r   = a[31:0];
            lat = 1;
        end else begin
            ma = (aw < 0) ? -aw : aw;
            mb = (bw < 0) ? -bw : bw;
            if (ma >= (mb <<< 32)) begin
                ovf = 1'b1;
                lat = 1;
            end else begin
                qq = aw / bw;
                rr = aw % bw;
                if (qq > 66'sd2147483647 || qq < -66'sd2147483648) begin
                    ovf = 1'b1;
                end else begin
                    q = qq[31:0];
                    r = rr[31:0];
                end
            end
        end
    endfunction

    // Launch one division and follow it to done. Optional: stall with en=0 for
    // pause_len cycles from cycle pause_at, pulse start at cycle junk_at while busy,
    // and hold en=0 for a few cycles once done is up.
    task automatic do_op(input logic signed [63:0] a, input logic signed [31:0] b,
                         input int pause_at, input int pause_len, input int junk_at,
                         input bit freeze_done,
                         output logic signed [31:0] q, output logic signed [31:0] r,
                         output logic dz, output logic ovf, output int lat);
        int busy_low;
        busy_low = 0;
        lat      = 0;
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        bus.en       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("flags cleared at start", 64'({bus.div_by_zero, bus.overflow}), 64'd0);
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.busy !== 1'b1) busy_low++;
            bus.en = !(lat >= pause_at && lat < pause_at + pause_len);
            if (lat == junk_at) begin
                bus.start    = 1'b1;
                bus.dividend = 64'sh0000_5A5A_A5A5_1234;
                bus.divisor  = 32'sd3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.en    = 1'b1;
        bus.start = 1'b0;
        check("done seen", 64'(bus.done), 64'd1);
        check("busy held until done", 64'(busy_low), 64'd0);
        check("busy cleared at done", 64'(bus.busy), 64'd0);
        q   = bus.quotient;
        r   = bus.remainder;
        dz  = bus.div_by_zero;
        ovf = bus.overflow;
        if (freeze_done) begin
            bus.en = 1'b0;
            repeat (3) @(negedge clk);
            check("done frozen by en=0", 64'(bus.done), 64'd1);
            bus.en = 1'b1;
        end
        @(negedge clk);
        check("done one cycle", 64'(bus.done), 64'd0);
    endtask

    task automatic check_result(input string tag,
                                input logic signed [31:0] q, input logic signed [31:0] r,
                                input logic dz, input logic ovf, input int lat,
                                input logic signed [31:0] eq, input logic signed [31:0] er,
                                input logic edz, input logic eovf, input int elat);
        check({tag, " quotient"}, 64'(q), 64'(eq));
        check({tag, " remainder"}, 64'(r), 64'(er));
        check({tag, " div_by_zero"}, 64'(dz), 64'(edz));
        check({tag, " overflow"}, 64'(ovf), 64'(eovf));
        check({tag, " latency"}, 64'(lat), 64'(elat));
    endtask

    initial begin
        logic signed [31:0] q, r, eq, er;
        logic               dz, ovf, edz, eovf;
        int                 lat, elat;
        logic signed [63:0] a;
        logic signed [31:0] b;
        bit                 done_seen;

        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{64'sd14,  32'sd2,  32'sd7,  32'sd0,  1'b0, 1'b0, 33};
        vecs[1]  = '{-64'sd21, 32'sd3,  -32'sd7, 32'sd0,  1'b0, 1'b0, 33};
        vecs[2]  = '{64'sd4,   -32'sd2, -32'sd2, 32'sd0,  1'b0, 1'b0, 33};
        vecs[3]  = '{64'sd22,  32'sd7,  32'sd3,  32'sd1,  1'b0, 1'b0, 33};
        vecs[4]  = '{-64'sd22, 32'sd7,  -32'sd3, -32'sd1, 1'b0, 1'b0, 33};
        vecs[5]  = '{64'sd22,  -32'sd7, -32'sd3, 32'sd1,  1'b0, 1'b0, 33};
        vecs[6]  = '{-64'sd22, -32'sd7, 32'sd3,  -32'sd1, 1'b0, 1'b0, 33};
        vecs[7]  = '{-64'sd60, 32'sd0,  -32'sd1, -32'sd60, 1'b1, 1'b0, 1};
        vecs[8]  = '{64'sh100_0000_0000, 32'sd2, 32'sd0, 32'sd0, 1'b0, 1'b1, 1};
        vecs[9]  = '{64'sh8000_0000, 32'sd1, 32'sd0, 32'sd0, 1'b0, 1'b1, 33};
        vecs[10] = '{-64'sh8000_0000, 32'sd1, 32'sh8000_0000, 32'sd0, 1'b0, 1'b0, 33};
        vecs[11] = '{64'sh8000_0000_0000_0000, -32'sd1, 32'sd0, 32'sd0, 1'b0, 1'b1, 1};
        vecs[12] = '{64'sd1000, 32'sd7, 32'sd142, 32'sd6, 1'b0, 1'b0, 33};

        reset        = 1'b1;
        bus.en       = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        check("reset quotient", 64'(bus.quotient), 64'd0);
        check("reset remainder", 64'(bus.remainder), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset div_by_zero", 64'(bus.div_by_zero), 64'd0);
        check("reset overflow", 64'(bus.overflow), 64'd0);
        reset  = 1'b0;
        bus.en = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].a, vecs[i].b, -1, 0, -1, 1'b0, q, r, dz, ovf, lat);
            $display("vec %0d: %0d / %0d -> q=%0d r=%0d dz=%0b ovf=%0b lat=%0d",
                     i, vecs[i].a, vecs[i].b, q, r, dz, ovf, lat);
            check_result("vec", q, r, dz, ovf, lat,
                         vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ovf, vecs[i].lat);
        end

        // en=0 stall of 10 cycles mid-CALC plus a start pulse while busy.
        do_op(64'sd22, -32'sd7, 5, 10, 3, 1'b0, q, r, dz, ovf, lat);
        $display("stall: 22 / -7 -> q=%0d r=%0d lat=%0d", q, r, lat);
        check_result("stall", q, r, dz, ovf, lat, -32'sd3, 32'sd1, 1'b0, 1'b0, 43);

        // done must stay high while en=0 after the done edge.
        do_op(64'sd14, 32'sd2, -1, 0, -1, 1'b1, q, r, dz, ovf, lat);
        $display("freeze: 14 / 2 -> q=%0d r=%0d lat=%0d", q, r, lat);
        check_result("freeze", q, r, dz, ovf, lat, 32'sd7, 32'sd0, 1'b0, 1'b0, 33);

        // Reset in the middle of CALC: everything clears, no done afterwards.
        @(negedge clk);
        bus.dividend = 64'sd1000;
        bus.divisor  = 32'sd7;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset quotient", 64'(bus.quotient), 64'd0);
        check("midreset busy", 64'(bus.busy), 64'd0);
        check("midreset done", 64'(bus.done), 64'd0);
        reset     = 1'b0;
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen = 1'b1;
        end
        check("no done after reset", 64'(done_seen), 64'd0);
        $display("reset mid-CALC: q=%0d busy=%0b", bus.quotient, bus.busy);

        do_op(64'sd200, -32'sd10, -1, 0, -1, 1'b0, q, r, dz, ovf, lat);
        $display("post-reset: 200 / -10 -> q=%0d r=%0d lat=%0d", q, r, lat);
        check_result("post-reset", q, r, dz, ovf, lat, -32'sd20, 32'sd0, 1'b0, 1'b0, 33);

        // Randomized operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom};
            a = a >>> $urandom_range(0, 63);
            b = $urandom;
            b = b >>> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) b = 32'sd0;
            ref_div(a, b, eq, er, edz, eovf, elat);
            do_op(a, b, -1, 0, -1, 1'b0, q, r, dz, ovf, lat);
            $display("rnd %0d: %0d / %0d -> q=%0d r=%0d dz=%0b ovf=%0b lat=%0d",
                     i, a, b, q, r, dz, ovf, lat);
            check_result("rnd", q, r, dz, ovf, lat, eq, er, edz, eovf, elat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
